// File: rtl/piradip_gain_ctrl_pkg.sv
// Shared types and constants for the gain ramp controller.
package piradip_gain_ctrl_pkg;

    typedef enum logic {IDLE, RAMP} gain_ramp_state_t;

    localparam int GAIN_WIDTH_DEFAULT = 18;

    function automatic int unsigned unity_gain(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

endpackage

// File: rtl/piradip_beat_interval_counter.sv
// Loadable down-counter of accepted stream beats; expire flags the strobe that
// takes the count from 1, a load value of 0 behaves as 1.
module piradip_beat_interval_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             strobe,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    assign expire = strobe && (count == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= (load_value == '0) ? WIDTH'(1) : load_value;
        end else if (strobe && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/piradip_gain_ramp_controller.sv
// Ramps the multiplier gain linearly toward a requested target, one step per
// programmable number of accepted beats, so gain changes never glitch the stream.
module piradip_gain_ramp_controller
    import piradip_gain_ctrl_pkg::*;
#(
    parameter int GAIN_WIDTH       = GAIN_WIDTH_DEFAULT,
    parameter int FRACTIONAL_WIDTH = 8,
    parameter int INTERVAL_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [GAIN_WIDTH-1:0] target_gain,
    input  logic                         target_valid,
    input  logic [GAIN_WIDTH-1:0]        step_size,
    input  logic [INTERVAL_WIDTH-1:0]    step_interval,
    input  logic                         sample_strobe,
    output logic signed [GAIN_WIDTH-1:0] gain_out,
    output logic                         busy,
    output logic                         done
);

    localparam logic signed [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(FRACTIONAL_WIDTH));

    gain_ramp_state_t              state;
    logic signed [GAIN_WIDTH-1:0]  target_q;
    logic [GAIN_WIDTH-1:0]         step_q;
    logic [INTERVAL_WIDTH-1:0]     interval_q;

    // One extra bit keeps target - gain exact across the full signed range.
    logic signed [GAIN_WIDTH:0]    diff;
    logic [GAIN_WIDTH:0]           diff_mag;
    logic [GAIN_WIDTH:0]           step_ext;
    logic signed [GAIN_WIDTH:0]    stepped;
    logic                          final_step;

    logic                          ramp_strobe;
    logic                          cnt_load;
    logic [INTERVAL_WIDTH-1:0]     cnt_value;
    logic                          expire;

    assign diff       = (GAIN_WIDTH+1)'(target_q) - (GAIN_WIDTH+1)'(gain_out);
    assign diff_mag   = diff[GAIN_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign step_ext   = {1'b0, step_q};
    assign final_step = (diff_mag <= step_ext) || (step_q == '0);
    assign stepped    = diff[GAIN_WIDTH]
                      ? (GAIN_WIDTH+1)'(gain_out) - $signed(step_ext)
                      : (GAIN_WIDTH+1)'(gain_out) + $signed(step_ext);

    assign ramp_strobe = sample_strobe && (state == RAMP);
    assign cnt_load    = ((state == IDLE) && target_valid) || (expire && !final_step);
    assign cnt_value   = (state == IDLE) ? step_interval : interval_q;

    piradip_beat_interval_counter #(
        .WIDTH (INTERVAL_WIDTH)
    ) u_interval (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .strobe     (ramp_strobe),
        .expire     (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gain_out   <= UNITY;
            busy       <= 1'b0;
            done       <= 1'b0;
            target_q   <= UNITY;
            step_q     <= '0;
            interval_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (target_valid) begin
                        target_q   <= target_gain;
                        step_q     <= step_size;
                        interval_q <= step_interval;
                        if (target_gain == gain_out) begin
                            done <= ~done;
                        end else if (step_size == '0) begin
                            gain_out <= target_gain;
                            done     <= ~done;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    // A coincident retarget only replaces the target; this step still uses the old one.
                    if (expire) begin
                        if (final_step) begin
                            gain_out <= target_q;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= ~done;
                        end else begin
                            gain_out <= stepped[GAIN_WIDTH-1:0];
                        end
                    end
                    if (target_valid) begin
                        target_q <= target_gain;
                        step_q   <= step_size;
                        if (!expire && (target_gain == gain_out)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= ~done;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
